// File: rtl/serial_shift_engine.sv
// Serial shift engine: shifts a DATA_W-bit word out MSB-first on a divided sclk
// while capturing an equal-length word from sdi, with a programmable sdo delay.
module serial_shift_engine #(
   parameter int DATA_W = 32,
   parameter int DIV_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Start,
   output logic              Busy,
   input  logic [DATA_W-1:0] DataOut,
   output logic [DATA_W-1:0] DataIn,
   input  logic [DIV_W-1:0]  ClockDiv,
   input  logic [DIV_W-1:0]  NegDel,
   output logic              sclk,
   output logic              cs_n,
   output logic              sdo,
   input  logic              sdi
);

   localparam int BC_W = $clog2(DATA_W) + 1;
   localparam logic [BC_W-1:0] BITS = BC_W'(DATA_W);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_HIGH  = 2'd2;
   localparam logic [1:0] S_LOW   = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [DIV_W-1:0]  half_q, half_d;
   logic [BC_W-1:0]   bit_q, bit_d;
   logic [DIV_W-1:0]  h_q, h_d;
   logic [DIV_W-1:0]  del_q, del_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              busy_q, busy_d;
   logic              sclk_q, sclk_d;
   logic              cs_n_q, cs_n_d;
   logic              sdo_q, sdo_d;

   logic [DIV_W-1:0]  h_new;
   logic [DIV_W-1:0]  d_new;
   logic              phase_end;

   // ClockDiv=0 behaves as a one-cycle half period; the delay is clamped so sdo
   // always settles at least one cycle before the next rising sclk edge.
   assign h_new     = (ClockDiv == '0) ? DIV_W'(1) : ClockDiv;
   assign d_new     = (NegDel < h_new) ? NegDel : h_new - DIV_W'(1);
   assign phase_end = (half_q == h_q - DIV_W'(1));

   always_comb begin
      // NOTE: every next-state signal gets a hold default first, so no path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      half_d  = half_q;
      bit_d   = bit_q;
      h_d     = h_q;
      del_d   = del_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      din_d   = din_q;
      busy_d  = busy_q;
      sclk_d  = sclk_q;
      cs_n_d  = cs_n_q;
      sdo_d   = sdo_q;

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               state_d = S_SETUP;
               busy_d  = 1'b1;
               cs_n_d  = 1'b0;
               sclk_d  = 1'b0;
               sdo_d   = DataOut[DATA_W-1];
               tx_d    = DataOut;
               h_d     = h_new;
               del_d   = d_new;
               half_d  = '0;
               bit_d   = '0;
               rx_d    = '0;
            end
         end
         S_SETUP: begin
            if (phase_end) begin
               state_d = S_HIGH;
               sclk_d  = 1'b1;
               half_d  = '0;
               rx_d    = {rx_q[DATA_W-2:0], sdi};
            end else begin
               half_d  = half_q + DIV_W'(1);
            end
         end
         S_HIGH: begin
            if (phase_end) begin
               state_d = S_LOW;
               sclk_d  = 1'b0;
               half_d  = '0;
               bit_d   = bit_q + BC_W'(1);
               if (del_q == '0 && (bit_q + BC_W'(1)) < BITS) begin
                  sdo_d = tx_q[DATA_W-2];
                  tx_d  = tx_q << 1;
               end
            end else begin
               half_d  = half_q + DIV_W'(1);
            end
         end
         default: begin
            if (del_q != '0 && half_q == del_q - DIV_W'(1) && bit_q < BITS) begin
               sdo_d = tx_q[DATA_W-2];
               tx_d  = tx_q << 1;
            end
            if (phase_end) begin
               half_d = '0;
               if (bit_q == BITS) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  cs_n_d  = 1'b1;
                  sdo_d   = 1'b0;
                  din_d   = rx_q;
                  bit_d   = '0;
               end else begin
                  state_d = S_HIGH;
                  sclk_d  = 1'b1;
                  rx_d    = {rx_q[DATA_W-2:0], sdi};
               end
            end else begin
               half_d = half_q + DIV_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
      if (rst) begin
         state_q <= S_IDLE;
         half_q  <= '0;
         bit_q   <= '0;
         h_q     <= '0;
         del_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         din_q   <= '0;
         busy_q  <= 1'b0;
         sclk_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         sdo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         half_q  <= half_d;
         bit_q   <= bit_d;
         h_q     <= h_d;
         del_q   <= del_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         din_q   <= din_d;
         busy_q  <= busy_d;
         sclk_q  <= sclk_d;
         cs_n_q  <= cs_n_d;
         sdo_q   <= sdo_d;
      end
   end

   assign Busy   = busy_q;
   assign DataIn = din_q;
   assign sclk   = sclk_q;
   assign cs_n   = cs_n_q;
   assign sdo    = sdo_q;

endmodule

// File: tb/tb_serial_shift_engine.sv
// Self-checking bench for serial_shift_engine: randomized transfers compared
// cycle by cycle against a waveform model derived from the transfer rules.
module tb_serial_shift_engine;

   localparam int N  = 32;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          Start = 1'b0;
   logic          Busy;
   logic [N-1:0]  DataOut = '0;
   logic [N-1:0]  DataIn;
   logic [DW-1:0] ClockDiv = '0;
   logic [DW-1:0] NegDel = '0;
   logic          sclk;
   logic          cs_n;
   logic          sdo;
   logic          sdi;
   logic          sdi_drv = 1'b1;
   logic          loop_en = 1'b0;

   int checks = 0;
   int errors = 0;

   assign sdi = loop_en ? sdo : sdi_drv;

   always #5 clk = ~clk;

   serial_shift_engine #(.DATA_W(N), .DIV_W(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .Start    (Start),
      .Busy     (Busy),
      .DataOut  (DataOut),
      .DataIn   (DataIn),
      .ClockDiv (ClockDiv),
      .NegDel   (NegDel),
      .sclk     (sclk),
      .cs_n     (cs_n),
      .sdo      (sdo),
      .sdi      (sdi)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int eff_h(input int cd);
      return (cd == 0) ? 1 : cd;
   endfunction

   function automatic int eff_d(input int nd, input int h);
      return (nd < h) ? nd : h - 1;
   endfunction

   // Bit j (counting from the MSB) becomes valid D cycles into the j-th LOW phase.
   function automatic logic exp_sdo(input logic [N-1:0] data, input int h, input int d, input int k);
      int j = 0;
      for (int jj = 1; jj < N; jj++)
         if (k >= 2 * jj * h + d) j = jj;
      return data[N-1-j];
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_pins"}, {60'd0, Busy, cs_n, sclk, sdo}, 64'h4);
      check({tag, "_datain"}, {32'd0, DataIn}, 64'd0);
   endtask

   // Called positioned at a falling edge; returns at a falling edge.
   // sdi_mode: 0 random per cycle, 1 tied high (ignored when loop=1).
   task automatic run_xfer(input string name, input logic [N-1:0] data, input int cd, input int nd,
                           input bit loop, input int sdi_mode, input int mid_k, input int rst_k,
                           input bit start_at_end);
      int           h, d, total, p;
      bit           hist[$];
      logic [N-1:0] exp_rx;
      logic         exp_sclk;
      h        = eff_h(cd);
      d        = eff_d(nd, h);
      total    = (2 * N + 1) * h;
      DataOut  = data;
      ClockDiv = DW'(cd);
      NegDel   = DW'(nd);
      loop_en  = loop;
      sdi_drv  = (sdi_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      Start    = 1'b1;
      for (int k = 0; k < total; k++) begin
         @(negedge clk);
         Start    = 1'b0;
         p        = k / h;
         exp_sclk = (p % 2) == 1;
         check($sformatf("%s_k%0d", name, k), {60'd0, Busy, cs_n, sclk, sdo},
               {60'd0, 1'b1, 1'b0, exp_sclk, exp_sdo(data, h, d, k)});
         if (k == rst_k) begin
            rst = 1'b1;
            @(negedge clk);
            check_reset_vals({name, "_midrst"});
            rst = 1'b0;
            return;
         end
         if (k == mid_k) begin
            Start    = 1'b1;
            DataOut  = ~data;
            ClockDiv = DW'(cd + 3);
            NegDel   = '0;
         end
         if (!loop && sdi_mode == 0) sdi_drv = 1'($urandom_range(0, 1));
         hist.push_back(loop ? sdo : sdi_drv);
         if (start_at_end && k == total - 1) Start = 1'b1;
      end
      for (int j = 0; j < N; j++) exp_rx[N-1-j] = hist[(2 * j + 1) * h - 1];
      @(negedge clk);
      check({name, "_idle"}, {60'd0, Busy, cs_n, sclk, sdo}, 64'h4);
      check({name, "_datain"}, {32'd0, DataIn}, {32'd0, exp_rx});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 1 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held for two cycles with Start and sdi high: nothing may launch.
      rst     = 1'b1;
      Start   = 1'b1;
      sdi_drv = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check_reset_vals("reset");
      end
      rst   = 1'b0;
      Start = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check_reset_vals("post_reset");
      end

      run_xfer("loop_h2", 32'hA5A5F00F, 2, 0, 1'b1, 0, -1, -1, 1'b0);
      check("loop_h2_literal", {32'd0, DataIn}, 64'hA5A5F00F);

      run_xfer("h1_ones", 32'h00000001, 0, 0, 1'b0, 1, -1, -1, 1'b0);
      check("h1_ones_literal", {32'd0, DataIn}, 64'hFFFFFFFF);

      run_xfer("del3", $urandom, 5, 3, 1'b1, 0, -1, -1, 1'b0);
      run_xfer("del9_clamp", $urandom, 5, 9, 1'b0, 0, -1, -1, 1'b0);

      run_xfer("mid_start", $urandom, 4, 1, 1'b1, 0, 11 * 4, -1, 1'b1);
      run_xfer("after_fall", $urandom, 2, 1, 1'b0, 0, -1, -1, 1'b0);

      run_xfer("rst_bit10", $urandom, 3, 0, 1'b1, 0, -1, 21 * 3 + 1, 1'b0);
      run_xfer("post_rst", $urandom, 3, 2, 1'b1, 0, -1, -1, 1'b0);

      for (int i = 0; i < 6; i++) begin
         run_xfer($sformatf("rand%0d", i), $urandom, int'($urandom_range(0, 6)),
                  int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), 0, -1, -1, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
